// File: rtl/cam_stream_if.sv
// rtl/cam_stream_if.sv - DVP stream, pixel fetch port and frame status of the camera emulator
interface cam_stream_if;
    logic        pix_req;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [11:0] pix_data;
    logic        vsync;
    logic        href;
    logic [7:0]  data;
    logic        frame_done;
    logic        busy;
    logic [7:0]  frame_cnt;

    modport master (
        output pix_req, pix_x, pix_y, vsync, href, data, frame_done, busy, frame_cnt,
        input  pix_data
    );

    modport slave (
        input  pix_req, pix_x, pix_y, vsync, href, data, frame_done, busy, frame_cnt,
        output pix_data
    );
endinterface

// File: rtl/cam_stream_gen.sv
// rtl/cam_stream_gen.sv - OV7670-style DVP camera stream generator (RGB444, two bytes per pixel)
module cam_stream_gen #(
    parameter int HWIDTH       = 640,
    parameter int VWIDTH       = 480,
    parameter int HBLANK       = 16,
    parameter int VSYNC_LINES  = 3,
    parameter int VBACK_LINES  = 17,
    parameter int VFRONT_LINES = 10
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    cam_stream_if.master cam
);
    localparam int LP      = 2 * HWIDTH + HBLANK;
    localparam int HW_BITS = $clog2(LP);

    localparam logic [HW_BITS-1:0] H_LAST    = HW_BITS'(LP - 1);
    localparam logic [HW_BITS-1:0] HACT_LAST = HW_BITS'(2 * HWIDTH - 1);
    localparam logic [9:0]         BAR_W     = 10'(HWIDTH / 8);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_VSYNC  = 3'd1;
    localparam logic [2:0] S_VBACK  = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_VFRONT = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [HW_BITS-1:0] hcnt_q, hcnt_d;
    logic [9:0]         vline_q, vline_d;
    logic [1:0]         sel_q, sel_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
    logic [11:0]        pix_hold_q, pix_hold_d;
    logic               vsync_q, vsync_d;
    logic               href_q, href_d;
    logic [7:0]         data_q, data_d;
    logic               pix_req_q, pix_req_d;
    logic [9:0]         pix_x_q, pix_x_d;
    logic [8:0]         pix_y_q, pix_y_d;
    logic               frame_done_q, frame_done_d;
    logic               busy_q, busy_d;

    logic [9:0]  last_line;
    logic        end_line, end_state;
    logic [9:0]  x_d;
    logic [8:0]  y_d;
    logic [2:0]  bar;
    logic [11:0] pix_val;
    logic        act_d;

    // Line and frame sequencing: hcnt walks the line period, vline counts line periods per state
    always_comb begin
        state_d     = state_q;
        hcnt_d      = hcnt_q;
        vline_d     = vline_q;
        sel_d       = sel_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            S_VSYNC:  last_line = 10'(VSYNC_LINES - 1);
            S_VBACK:  last_line = 10'(VBACK_LINES - 1);
            S_ACTIVE: last_line = 10'(VWIDTH - 1);
            default:  last_line = 10'(VFRONT_LINES - 1);
        endcase
        end_line  = (hcnt_q == H_LAST);
        end_state = end_line && (vline_q == last_line);
        if (state_q == S_IDLE) begin
            if (enable) begin
                state_d = S_VSYNC;
                hcnt_d  = '0;
                vline_d = '0;
            end
        end else begin
            hcnt_d = end_line ? '0 : hcnt_q + 1'b1;
            if (end_line) begin
                vline_d = end_state ? '0 : vline_q + 1'b1;
            end
            if (end_state) begin
                case (state_q)
                    S_VSYNC: begin
                        state_d = S_VBACK;
                        sel_d   = pattern_sel;
                    end
                    S_VBACK:  state_d = S_ACTIVE;
                    S_ACTIVE: state_d = S_VFRONT;
                    S_VFRONT: begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        state_d     = enable ? S_VSYNC : S_IDLE;
                    end
                    default:  state_d = S_IDLE;
                endcase
            end
        end
    end

    // Output stage: outputs are computed from the next position so they line up with the state registers
    always_comb begin
        act_d   = (state_d == S_ACTIVE);
        x_d     = 10'(hcnt_d >> 1);
        y_d     = 9'(vline_d);
        bar     = 3'(x_d / BAR_W);
        href_d  = act_d && (hcnt_d <= HACT_LAST);
        vsync_d = (state_d == S_VSYNC);
        busy_d  = (state_d != S_IDLE);
        frame_done_d = (state_d == S_VFRONT) && (hcnt_d == H_LAST)
                       && (vline_d == 10'(VFRONT_LINES - 1));
        pix_hold_d = pix_req_q ? cam.pix_data : pix_hold_q;

        case (bar)
            3'd0:    pix_val = 12'hFFF;
            3'd1:    pix_val = 12'hFF0;
            3'd2:    pix_val = 12'h0FF;
            3'd3:    pix_val = 12'h0F0;
            3'd4:    pix_val = 12'hF0F;
            3'd5:    pix_val = 12'hF00;
            3'd6:    pix_val = 12'h00F;
            default: pix_val = 12'h000;
        endcase
        case (sel_q)
            2'd0:    pix_val = hcnt_d[0] ? pix_hold_q : cam.pix_data;
            2'd2:    pix_val = {x_d[3:0], y_d[3:0], frame_cnt_q[3:0]};
            2'd3:    pix_val = (x_d[5] ^ y_d[5]) ? 12'hFFF : 12'h000;
            default: ;
        endcase
        data_d = '0;
        if (href_d) begin
            data_d = hcnt_d[0] ? pix_val[7:0] : {4'h0, pix_val[11:8]};
        end

        // Fetch one cycle ahead of byte0: inside the line, in the last blank cycle, or the last VBACK cycle
        pix_req_d = 1'b0;
        pix_x_d   = pix_x_q;
        pix_y_d   = pix_y_q;
        if (sel_q == 2'd0) begin
            if (act_d && hcnt_d[0] && (hcnt_d < HACT_LAST)) begin
                pix_req_d = 1'b1;
                pix_x_d   = 10'((hcnt_d + 1'b1) >> 1);
                pix_y_d   = y_d;
            end else if (act_d && (hcnt_d == H_LAST) && (vline_d != 10'(VWIDTH - 1))) begin
                pix_req_d = 1'b1;
                pix_x_d   = '0;
                pix_y_d   = y_d + 9'd1;
            end else if ((state_d == S_VBACK) && (hcnt_d == H_LAST)
                         && (vline_d == 10'(VBACK_LINES - 1))) begin
                pix_req_d = 1'b1;
                pix_x_d   = '0;
                pix_y_d   = '0;
            end
        end
    end

    // State and output registers with synchronous reset that aborts any frame in progress
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            hcnt_q       <= '0;
            vline_q      <= '0;
            sel_q        <= '0;
            frame_cnt_q  <= '0;
            pix_hold_q   <= '0;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            data_q       <= '0;
            pix_req_q    <= 1'b0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hcnt_q       <= hcnt_d;
            vline_q      <= vline_d;
            sel_q        <= sel_d;
            frame_cnt_q  <= frame_cnt_d;
            pix_hold_q   <= pix_hold_d;
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            data_q       <= data_d;
            pix_req_q    <= pix_req_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign cam.vsync      = vsync_q;
    assign cam.href       = href_q;
    assign cam.data       = data_q;
    assign cam.pix_req    = pix_req_q;
    assign cam.pix_x      = pix_x_q;
    assign cam.pix_y      = pix_y_q;
    assign cam.frame_done = frame_done_q;
    assign cam.busy       = busy_q;
    assign cam.frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_cam_stream_gen.sv
// tb/tb_cam_stream_gen.sv - self-checking bench for cam_stream_gen against a frame-position reference model
module tb_cam_stream_gen;
    localparam int HW   = 8;
    localparam int VW   = 4;
    localparam int HB   = 4;
    localparam int VSL  = 1;
    localparam int VBL  = 1;
    localparam int VFL  = 1;
    localparam int LP   = 2 * HW + HB;
    localparam int FLEN = (VSL + VBL + VW + VFL) * LP;

    logic       pclk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] pattern_sel = 2'd0;
    int         tests = 0;
    int         fails = 0;

    cam_stream_if cam ();

    cam_stream_gen #(
        .HWIDTH(HW), .VWIDTH(VW), .HBLANK(HB),
        .VSYNC_LINES(VSL), .VBACK_LINES(VBL), .VFRONT_LINES(VFL)
    ) dut (
        .pclk(pclk),
        .rst(rst),
        .enable(enable),
        .pattern_sel(pattern_sel),
        .cam(cam)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] pix_model(input int sel, input int x, input int y, input int fc);
        logic [11:0] p;
        case (sel)
            0: p = {4'(y), 4'(x), 4'hA};
            1: case (x / (HW / 8))
                   0: p = 12'hFFF;
                   1: p = 12'hFF0;
                   2: p = 12'h0FF;
                   3: p = 12'h0F0;
                   4: p = 12'hF0F;
                   5: p = 12'hF00;
                   6: p = 12'h00F;
                   default: p = 12'h000;
               endcase
            2: p = {4'(x), 4'(y), 4'(fc)};
            default: p = (((x >> 5) ^ (y >> 5)) & 1) != 0 ? 12'hFFF : 12'h000;
        endcase
        return p;
    endfunction

    // Expected DVP outputs at cycle c of a frame, c = 0 being the first vsync cycle
    task automatic model(input int c, input int sel, input int fc,
                         output logic vs, output logic hr, output logic [7:0] d,
                         output logic rq, output int px, output int py, output logic dn);
        int line, h, line2, h2;
        logic act, act2;
        logic [11:0] p;
        line = c / LP;
        h    = c % LP;
        act  = (line >= VSL + VBL) && (line < VSL + VBL + VW);
        vs   = (line < VSL);
        hr   = act && (h < 2 * HW);
        p    = pix_model(sel, h / 2, line - VSL - VBL, fc);
        d    = !hr ? 8'h00 : ((h % 2 == 0) ? {4'h0, p[11:8]} : p[7:0]);
        line2 = (c + 1) / LP;
        h2    = (c + 1) % LP;
        act2  = (line2 >= VSL + VBL) && (line2 < VSL + VBL + VW);
        rq = (sel == 0) && act2 && (h2 < 2 * HW) && (h2 % 2 == 0);
        px = h2 / 2;
        py = line2 - VSL - VBL;
        dn = (c == FLEN - 1);
    endtask

    // External frame-buffer stand-in: answers a request, otherwise drives noise
    task automatic drive_pix();
        if (cam.pix_req) cam.pix_data = {cam.pix_y[3:0], cam.pix_x[3:0], 4'hA};
        else             cam.pix_data = 12'($urandom);
    endtask

    task automatic run_frame(input int sel, input int fc, input int ncyc,
                             input int chg_c, input logic [1:0] chg_sel, input int drop_c);
        logic vs, hr, rq, dn, prev_hr;
        logic [7:0] d;
        int px, py, reqs, vs_cnt, rises;
        reqs = 0; vs_cnt = 0; rises = 0; prev_hr = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge pclk);
            model(c, sel, fc, vs, hr, d, rq, px, py, dn);
            chk($sformatf("vsync f%0d c%0d", fc, c), 32'(cam.vsync), 32'(vs));
            chk($sformatf("href f%0d c%0d", fc, c), 32'(cam.href), 32'(hr));
            chk($sformatf("data f%0d c%0d", fc, c), 32'(cam.data), 32'(d));
            chk($sformatf("pix_req f%0d c%0d", fc, c), 32'(cam.pix_req), 32'(rq));
            chk($sformatf("frame_done f%0d c%0d", fc, c), 32'(cam.frame_done), 32'(dn));
            chk($sformatf("busy f%0d c%0d", fc, c), 32'(cam.busy), 32'd1);
            chk($sformatf("frame_cnt f%0d c%0d", fc, c), 32'(cam.frame_cnt), 32'(fc));
            if (rq) begin
                chk($sformatf("pix_x f%0d c%0d", fc, c), 32'(cam.pix_x), 32'(px));
                chk($sformatf("pix_y f%0d c%0d", fc, c), 32'(cam.pix_y), 32'(py));
            end
            if (cam.pix_req) reqs++;
            if (cam.vsync) vs_cnt++;
            if (cam.href && !prev_hr) rises++;
            prev_hr = cam.href;
            drive_pix();
            if (c == chg_c) pattern_sel = chg_sel;
            if (c == drop_c) enable = 1'b0;
        end
        if (ncyc == FLEN) begin
            chk($sformatf("vsync_len f%0d", fc), 32'(vs_cnt), 32'(VSL * LP));
            chk($sformatf("href_pulses f%0d", fc), 32'(rises), 32'(VW));
            chk($sformatf("req_count f%0d", fc), 32'(reqs), (sel == 0) ? 32'(HW * VW) : 32'd0);
        end
    endtask

    task automatic chk_quiet(input string tag, input int fc);
        chk({tag, " vsync"}, 32'(cam.vsync), 32'd0);
        chk({tag, " href"}, 32'(cam.href), 32'd0);
        chk({tag, " data"}, 32'(cam.data), 32'd0);
        chk({tag, " busy"}, 32'(cam.busy), 32'd0);
        chk({tag, " pix_req"}, 32'(cam.pix_req), 32'd0);
        chk({tag, " frame_done"}, 32'(cam.frame_done), 32'd0);
        chk({tag, " frame_cnt"}, 32'(cam.frame_cnt), 32'(fc));
    endtask

    initial begin
        int chg_c, drop_c;
        cam.pix_data = 12'h000;

        rst = 1'b1;
        repeat (3) @(negedge pclk);
        chk_quiet("reset", 0);
        chk("reset pix_x", 32'(cam.pix_x), 32'd0);
        chk("reset pix_y", 32'(cam.pix_y), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge pclk);
        chk_quiet("idle", 0);

        enable = 1'b1;
        pattern_sel = 2'd1;
        run_frame(1, 0, FLEN, -1, 2'd0, -1);
        pattern_sel = 2'd0;
        run_frame(0, 1, FLEN, -1, 2'd0, -1);
        pattern_sel = 2'd2;
        run_frame(2, 2, FLEN, -1, 2'd0, -1);

        pattern_sel = 2'd1;
        chg_c = $urandom_range(41, 110);
        run_frame(1, 3, FLEN, chg_c, 2'd3, -1);
        drop_c = $urandom_range(45, 115);
        run_frame(3, 4, FLEN, -1, 2'd0, drop_c);

        for (int i = 0; i < 30; i++) begin
            @(negedge pclk);
            drive_pix();
            if (i % 10 == 9) chk_quiet($sformatf("after_disable %0d", i), 5);
        end

        enable = 1'b1;
        pattern_sel = 2'd1;
        run_frame(1, 5, (VSL + VBL) * LP + 8, -1, 2'd0, -1);
        rst = 1'b1;
        @(negedge pclk);
        chk_quiet("mid_line_reset", 0);
        rst = 1'b0;
        @(negedge pclk);
        chk("restart vsync", 32'(cam.vsync), 32'd1);
        chk("restart busy", 32'(cam.busy), 32'd1);
        chk("restart href", 32'(cam.href), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cam_stream_gen.md
Name: cam_stream_gen

Overview:
- Generates an OV7670-style DVP camera stream (vsync, href, 8-bit data, two bytes per RGB444 pixel) on pclk.
- It is the transmit-side counterpart of the camera capture path in the memory controller.
- Used as an on-chip camera emulator for bring-up and regression, so the capture, frame-buffer and ALU paths run without a physical sensor.
- Pixel source is an internal test pattern or an external fetch port (frame-buffer replay).

Parameters:
- HWIDTH, 640, active pixels per line; must be a multiple of 8.
- VWIDTH, 480, active lines per frame.
- HBLANK, 16, pclk cycles with href low after each active line; minimum 4.
- VSYNC_LINES, 3, line periods with vsync high.
- VBACK_LINES, 17, blank line periods between vsync fall and first active line.
- VFRONT_LINES, 10, blank line periods after last active line.

Ports:
- pclk  in  1  pixel clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  start/continue frames
- pattern_sel  in  2  0 external, 1 colour bars, 2 gradient, 3 checkerboard
- pix_req  out  1  external pixel fetch strobe
- pix_x  out  10  column of requested pixel
- pix_y  out  9  row of requested pixel
- pix_data  in  12  {R,G,B} RGB444, valid the cycle after pix_req
- vsync  out  1  frame sync, active high
- href  out  1  line valid
- data  out  8  DVP byte
- frame_done  out  1  one-cycle pulse at end of VFRONT
- busy  out  1  high in any state other than IDLE
- frame_cnt  out  8  completed frames, wraps 255->0

Behaviour:
- Reset: synchronous, active-high, on pclk.
  - While rst is high, the next edge forces state IDLE and all counters to 0.
  - Outputs forced low: vsync, href, data, pix_req, pix_x, pix_y, frame_done, busy, frame_cnt.
  - Reset mid-frame aborts immediately; no partial line is completed.
- Line period: LP = 2*HWIDTH + HBLANK cycles.
- hcnt counts 0..LP-1; vline counts line periods within the current state.
- FSM states:
  - IDLE: outputs low. enable=1 -> VSYNC.
  - VSYNC: vsync=1 for VSYNC_LINES*LP cycles -> VBACK. pattern_sel is latched on this exit and held for the whole frame.
  - VBACK: VBACK_LINES*LP cycles -> ACTIVE.
  - ACTIVE: per line, href=1 for cycles hcnt 0..2*HWIDTH-1, then href=0 for HBLANK cycles.
    - After VWIDTH lines -> VFRONT.
  - VFRONT: VFRONT_LINES*LP cycles.
    - On the last cycle: frame_done pulses and frame_cnt increments.
    - Next state is VSYNC if enable=1, else IDLE.
- enable dropping mid-frame does not truncate the frame.
- Byte order for pixel x of line y (hcnt = 2x and 2x+1):
  - byte0 = {4'h0, R}
  - byte1 = {G, B}
- Output timing:
  - vsync, href and data are registered and change on the same edge, so data is stable whenever href is high.
  - data = 0 whenever href = 0.
- External source (latched sel = 0):
  - pix_req=1 for one cycle, one cycle before byte0 of each pixel, with pix_x = x and pix_y = y.
  - pix_data is captured on the following edge and held for both bytes.
  - For pixel 0, the request falls in the last blanking cycle, or the last VBACK cycle for line 0.
  - pix_req stays 0 for internal patterns.
- Internal patterns (frame uses latched sel):
  - Colour bars: bar = x / (HWIDTH/8). Bars 0..7 = FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - Gradient: R = x[3:0], G = y[3:0], B = frame_cnt[3:0] (value at frame start).
  - Checkerboard: FFF if x[5]^y[5], else 000.
- Widths: pix_x and pix_y hold the last requested value between requests. frame_cnt wraps modulo 256.

Test Plan:
- Test parameters for all scenarios: HWIDTH=8, VWIDTH=4, HBLANK=4, VSYNC/VBACK/VFRONT_LINES=1, LP=20, frame length 140 cycles.
- Colour bars: sel=1, enable=1.
  - vsync high exactly 20 cycles.
  - First href rise 20 cycles after vsync fall; 4 href pulses of 16 cycles each, 4-cycle gaps.
  - data sequence on line 0: 0F,FF, 0F,F0, 00,FF, 00,F0, 0F,0F, 0F,00, 00,0F, 00,00.
- External replay: sel=0, model returns pix_data = {y[3:0], x[3:0], 4'hA}.
  - Exactly 32 pix_req pulses per frame, each one cycle before byte0.
  - Line 2 pixel 5 yields bytes 02, 5A.
- Multi-frame: enable held 3 frames.
  - frame_done pulses at cycles 140, 280, 420 after start; frame_cnt = 3.
  - Gradient (sel=2) on frame index 2 gives byte1 low nibble = 2.
- Mid-frame pattern change and disable:
  - sel changed 1->3 during ACTIVE leaves the current frame as colour bars; the next frame is checkerboard (all 00 for x,y<32).
  - enable deasserted mid-frame: the frame completes, then busy=0 and vsync stays low.
- Reset mid-line: rst high for 1 cycle at hcnt=7.
  - Next cycle: href=0, data=00, vsync=0, frame_cnt=0, busy=0.
  - With enable still high, vsync rises on the following cycle.
